// File: rtl/uart_pkg.sv
// Shared UART definitions: register offsets, SE bit positions, TX FSM states
// and bit-width arithmetic. Used by both the transmitter and the protocol checker.
package uart_pkg;

  localparam int UART_BW_W = 13;

  localparam logic [4:0] UART_DATA_ADDR = 5'h00;
  localparam logic [4:0] UART_SE_ADDR   = 5'h04;
  localparam logic [4:0] UART_BR_ADDR   = 5'h08;
  localparam logic [4:0] UART_STAT_ADDR = 5'h0C;

  localparam int UART_SE_TX_EN   = 0;
  localparam int UART_SE_PAR_EN  = 1;
  localparam int UART_SE_PAR_ODD = 2;

  // pwdata bit that clears the sticky overflow flag on a STATUS write
  localparam int UART_STAT_OVF_CLR = 3;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } uart_tx_state_e;

  // 16*(br+1): 16..4096 cycles per bit
  function automatic logic [UART_BW_W-1:0] uart_bit_width(input logic [7:0] br);
    return {1'b0, br, 4'b0000} + 13'd16;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with show-ahead read data; a pop in the same cycle
// frees space for a push when full.
module uart_tx_fifo #(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [7:0]    i_wdata,
  input  logic          i_pop,
  output logic [7:0]    o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count,
  output logic          o_drop
);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_rd;
  logic          w_wr;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  assign w_rd   = i_pop & ~o_empty;
  assign w_wr   = i_push & (~o_full | w_rd);
  assign o_drop = i_push & o_full & ~w_rd;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PW'(1);
      if (w_rd) r_rptr <= r_rptr + PW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_transmitter.sv
// APB-programmed UART transmitter: register decode, TX FIFO and frame FSM.
// Frame parameters are latched at pop so mid-frame register writes take effect next frame.
module uart_frame_transmitter
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        pclk,
  input  logic        preset_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        uart_tx,
  output logic        tx_busy,
  output logic        fifo_full,
  output logic        fifo_empty
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [4:0]           w_addr;
  logic                 w_wr;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_drop;
  logic [7:0]           w_fifo_data;
  logic [CW-1:0]        w_count;
  logic [31:0]          w_status;
  logic                 w_par;
  logic [UART_BW_W-1:0] w_bw_m1;
  logic                 w_term;

  logic [2:0]           r_se;
  logic [7:0]           r_br;
  logic                 r_ovf;
  logic [31:0]          r_prdata;

  uart_tx_state_e       r_state;
  uart_tx_state_e       w_state_nxt;
  logic [UART_BW_W-1:0] r_cnt;
  logic [UART_BW_W-1:0] w_cnt_nxt;
  logic [2:0]           r_idx;
  logic [2:0]           w_idx_nxt;
  logic                 r_tx;
  logic                 w_tx_nxt;
  logic                 r_busy;
  logic [7:0]           r_data;
  logic [7:0]           r_br_l;
  logic                 r_par_en_l;
  logic                 r_par_odd_l;

  logic                 w_unused;

  assign w_unused = &{1'b0, paddr[31:5], pwdata[31:8]};

  assign w_addr = paddr[4:0];
  assign w_wr   = psel & penable & pwrite & (&pstrb);
  assign w_push = w_wr & (w_addr == UART_DATA_ADDR);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (pclk),
    .rst_n   (preset_n),
    .i_push  (w_push),
    .i_wdata (pwdata[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_drop  (w_drop)
  );

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_se  <= '0;
      r_br  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr && w_addr == UART_SE_ADDR) r_se <= pwdata[2:0];
      if (w_wr && w_addr == UART_BR_ADDR) r_br <= pwdata[7:0];
      if (w_drop)
        r_ovf <= 1'b1;
      else if (w_wr && w_addr == UART_STAT_ADDR && pwdata[UART_STAT_OVF_CLR])
        r_ovf <= 1'b0;
    end
  end

  assign w_status = {24'b0, 4'(w_count), r_ovf, w_full, w_empty, r_busy};

  // Loaded during the APB setup cycle so it is stable through the access cycle
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) r_prdata <= '0;
    else           r_prdata <= (psel && !pwrite && w_addr == UART_STAT_ADDR) ? w_status : '0;
  end

  assign w_bw_m1 = uart_bit_width(r_br_l) - 13'd1;
  assign w_term  = (r_cnt == w_bw_m1);
  assign w_par   = r_par_odd_l ? ~^r_data : ^r_data;

  // uart_tx is registered from the next-state value, so it changes on the transition edge
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 13'd1;
    w_idx_nxt   = r_idx;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      TX_IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        w_tx_nxt  = 1'b1;
        if (r_se[UART_SE_TX_EN] && !w_empty) begin
          w_state_nxt = TX_START;
          w_pop       = 1'b1;
          w_tx_nxt    = 1'b0;
        end
      end
      TX_START: begin
        if (w_term) begin
          w_state_nxt = TX_DATA;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_tx_nxt    = r_data[0];
        end
      end
      TX_DATA: begin
        if (w_term) begin
          w_cnt_nxt = '0;
          if (r_idx == 3'd7) begin
            if (r_par_en_l) begin
              w_state_nxt = TX_PARITY;
              w_tx_nxt    = w_par;
            end else begin
              w_state_nxt = TX_STOP;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_idx_nxt = r_idx + 3'd1;
            w_tx_nxt  = r_data[r_idx + 3'd1];
          end
        end
      end
      TX_PARITY: begin
        if (w_term) begin
          w_state_nxt = TX_STOP;
          w_cnt_nxt   = '0;
          w_tx_nxt    = 1'b1;
        end
      end
      TX_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_term) begin
          w_state_nxt = TX_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = TX_IDLE;
        w_cnt_nxt   = '0;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state     <= TX_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_data      <= '0;
      r_br_l      <= '0;
      r_par_en_l  <= 1'b0;
      r_par_odd_l <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != TX_IDLE);
      if (w_pop) begin
        r_data      <= w_fifo_data;
        r_br_l      <= r_br;
        r_par_en_l  <= r_se[UART_SE_PAR_EN];
        r_par_odd_l <= r_se[UART_SE_PAR_ODD];
      end
    end
  end

  assign prdata     = r_prdata;
  assign pready     = 1'b1;
  assign uart_tx    = r_tx;
  assign tx_busy    = r_busy;
  assign fifo_full  = w_full;
  assign fifo_empty = w_empty;

endmodule

// File: tb/tb_uart_frame_transmitter.sv
// Bench for uart_frame_transmitter: register table, then frame scenarios checked
// by a line monitor against a queue of expected frames.
module tb_uart_frame_transmitter;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, uart_tx, tx_busy, fifo_full, fifo_empty;

  uart_frame_transmitter #(.FIFO_DEPTH(4)) dut (
    .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .uart_tx(uart_tx), .tx_busy(tx_busy), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );

  always #5 pclk = ~pclk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    bit         par_en;
    bit         par_odd;
    int         bw;
    bit         b2b;
  } frm_t;
  frm_t exp_q[$];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[13];

  bit mon_en   = 1'b1;
  bit in_frame = 1'b0;
  int cur_br = 0;
  bit cur_par_en = 0, cur_par_odd = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit ones_odd(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return (n % 2) == 1;
  endfunction

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge pclk);
    psel = 1; pwrite = 1; penable = 0; paddr = a; pwdata = d; pstrb = s;
    @(negedge pclk);
    penable = 1;
    @(negedge pclk);
    psel = 0; penable = 0; pwrite = 0; pstrb = 0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge pclk);
    psel = 1; pwrite = 0; penable = 0; paddr = a;
    @(negedge pclk);
    penable = 1;
    d = prdata;
    @(negedge pclk);
    psel = 0; penable = 0;
  endtask

  task automatic cfg(input logic [31:0] a, input logic [31:0] d);
    if (a == 32'h08) cur_br = int'(d[7:0]);
    if (a == 32'h04) begin cur_par_en = d[1]; cur_par_odd = d[2]; end
    apb_write(a, d, 4'hF);
  endtask

  task automatic expect_frame(input logic [7:0] d, input bit b2b);
    frm_t f;
    f.d = d; f.par_en = cur_par_en; f.par_odd = cur_par_odd;
    f.bw = 16 * (cur_br + 1); f.b2b = b2b;
    exp_q.push_back(f);
  endtask

  task automatic send(input logic [7:0] d, input bit b2b);
    expect_frame(d, b2b);
    apb_write(32'h00, {24'b0, d}, 4'hF);
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    apb_read(a, v);
    chk(nm, v, exp);
  endtask

  task automatic wait_drain(input string nm, input int maxc);
    int k = 0;
    while ((exp_q.size() != 0 || in_frame) && k < maxc) begin
      @(negedge pclk);
      k++;
    end
    chk({nm, "_drain"}, exp_q.size() + int'(in_frame), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge pclk);
    preset_n = 0;
    repeat (2) @(negedge pclk);
    preset_n = 1;
    cur_br = 0; cur_par_en = 0; cur_par_odd = 0;
  endtask

  // Line monitor: each bit must hold its level for exactly bw samples
  initial begin : monitor
    frm_t e;
    logic [10:0] bits;
    int nb, start_c, last_end;
    bit ok;
    last_end = -100;
    forever begin
      @(negedge pclk);
      if (mon_en && preset_n && uart_tx === 1'b0) begin
        in_frame = 1;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
          for (int k = 0; k < 20000 && tx_busy === 1'b1; k++) @(negedge pclk);
        end else begin
          e = exp_q.pop_front();
          start_c = cyc;
          if (e.b2b) chk("idle_gap", start_c - last_end - 1, 1);
          bits = '1;
          bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) bits[i+1] = e.d[i];
          nb = 10;
          if (e.par_en) begin
            bits[9] = e.par_odd ? ~ones_odd(e.d) : ones_odd(e.d);
            nb = 11;
          end
          for (int b = 0; b < nb; b++) begin
            ok = 1;
            for (int c = 0; c < e.bw; c++) begin
              if (b != 0 || c != 0) @(negedge pclk);
              if (uart_tx !== bits[b] || tx_busy !== 1'b1) ok = 0;
            end
            chk($sformatf("frame_%02h_bit%0d", e.d, b), ok, 1);
          end
          last_end = cyc;
          @(negedge pclk);
          chk("busy_drop", {30'b0, uart_tx, tx_busy}, 32'h2);
        end
        in_frame = 0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    int lows;
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0;
    preset_n = 0;

    tbl[0]  = '{0, 32'h0C, 32'h00, 4'h0, 32'h02};
    tbl[1]  = '{0, 32'h2C, 32'h00, 4'h0, 32'h02};
    tbl[2]  = '{0, 32'h00, 32'h00, 4'h0, 32'h00};
    tbl[3]  = '{1, 32'h00, 32'h99, 4'h7, 32'h00};
    tbl[4]  = '{0, 32'h0C, 32'h00, 4'h0, 32'h02};
    tbl[5]  = '{1, 32'h00, 32'hA5, 4'hF, 32'h00};
    tbl[6]  = '{0, 32'h0C, 32'h00, 4'h0, 32'h10};
    tbl[7]  = '{1, 32'h04, 32'h06, 4'hF, 32'h00};
    tbl[8]  = '{0, 32'h04, 32'h00, 4'h0, 32'h00};
    tbl[9]  = '{1, 32'h00, 32'h5A, 4'hF, 32'h00};
    tbl[10] = '{0, 32'h0C, 32'h00, 4'h0, 32'h20};
    tbl[11] = '{1, 32'h0C, 32'h08, 4'hF, 32'h00};
    tbl[12] = '{0, 32'h0C, 32'h00, 4'h0, 32'h20};

    repeat (3) @(negedge pclk);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_fifo_empty", fifo_empty, 1);
    chk("rst_fifo_full", fifo_full, 0);
    chk("rst_prdata", prdata, 0);
    chk("pready", pready, 1);
    preset_n = 1;

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].wr) apb_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
      else rd_chk($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp);
    end
    do_reset();
    rd_chk("post_tbl_reset_status", 32'h0C, 32'h02);

    // 8N1 at 16 cycles per bit
    cfg(32'h08, 0); cfg(32'h04, 1);
    send(8'h55, 0);
    wait_drain("t1", 3000);

    // even then odd parity at 48 cycles per bit
    cfg(32'h08, 2); cfg(32'h04, 3);
    send(8'h07, 0);
    wait_drain("t2_even", 3000);
    cfg(32'h04, 7);
    send(8'h07, 0);
    wait_drain("t2_odd", 3000);

    // overflow with transmitter disabled, then drain back-to-back
    cfg(32'h04, 0); cfg(32'h08, 0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_frame(8'(8'h11 * (i + 1)), i > 0);
      apb_write(32'h00, 32'(8'h11 * (i + 1)), 4'hF);
    end
    rd_chk("ovf_status", 32'h0C, 32'h4C);
    cfg(32'h04, 1);
    wait_drain("ovf", 4000);
    repeat (60) @(negedge pclk);
    rd_chk("ovf_after_status", 32'h0C, 32'h0A);
    apb_write(32'h0C, 32'h08, 4'hF);
    rd_chk("ovf_cleared", 32'h0C, 32'h02);

    // BR change mid-frame applies only to the next frame
    send(8'hA3, 0);
    repeat (40) @(negedge pclk);
    cfg(32'h08, 1);
    send(8'h3C, 1);
    wait_drain("brchg", 3000);

    // tx_en cleared during start bit: first frame completes, second stays queued
    cfg(32'h08, 0);
    send(8'h81, 0);
    apb_write(32'h00, 32'h18, 4'hF);
    cfg(32'h04, 0);
    wait_drain("dis", 3000);
    repeat (40) @(negedge pclk);
    rd_chk("dis_status", 32'h0C, 32'h10);

    // asynchronous reset during DATA
    mon_en = 0;
    apb_write(32'h04, 32'h1, 4'hF);
    apb_write(32'h00, 32'h77, 4'hF);
    repeat (30) @(negedge pclk);
    chk("pre_rst_busy", tx_busy, 1);
    #2 preset_n = 0;
    #1;
    chk("async_rst_uart_tx", uart_tx, 1);
    chk("async_rst_busy", tx_busy, 0);
    chk("async_rst_fifo_empty", fifo_empty, 1);
    repeat (2) @(negedge pclk);
    preset_n = 1;
    cur_br = 0; cur_par_en = 0; cur_par_odd = 0;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge pclk);
      if (uart_tx !== 1'b1) lows++;
    end
    chk("post_rst_idle_line", lows, 0);
    rd_chk("post_rst_status", 32'h0C, 32'h02);
    mon_en = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
